// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 frame states, frame constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        RELEASE
    } ps2_state_e;

    localparam int DATA_BITS   = 8;
    localparam int PARITY_EDGE = 9;
    localparam int STOP_EDGE   = 10;
    localparam int ACK_EDGE    = 11;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

// File: rtl/ps2_clk_edge.sv
// rtl/ps2_clk_edge.sv - registers a debounced PS/2 line and flags its falling/rising edges
module ps2_clk_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_fall,
    output logic o_rise
);

    logic r_line_q;

    // Idle level of an open-drain PS/2 line is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_q <= 1'b1;
        end else begin
            r_line_q <= i_line;
        end
    end

    assign o_fall = r_line_q & ~i_line;
    assign o_rise = ~r_line_q & i_line;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with request-to-send and timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       tx_nack
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_PRE   = CW'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_e      r_state,  w_state_n;
    logic [CW-1:0]   r_cnt,    w_cnt_n;
    logic [7:0]      r_shift,  w_shift_n;
    logic            r_parity, w_parity_n;
    logic [3:0]      r_edge,   w_edge_n;
    logic            r_clk_oe, w_clk_oe_n;
    logic            r_data_oe, w_data_oe_n;
    logic            r_done,   w_done_n;
    logic            r_error,  w_error_n;
    logic            r_nack,   w_nack_n;

    logic            w_fall;
    logic            w_rise_unused;
    logic            w_tout;
    logic            w_abort;

    ps2_clk_edge u_clk_edge (
        .clk    (clk),
        .reset  (reset),
        .i_line (ps2_clk),
        .o_fall (w_fall),
        .o_rise (w_rise_unused)
    );

    // Counter reaches TIMEOUT_CYCLES on the next edge without a device clock edge.
    assign w_tout = ~w_fall & (r_cnt == TOUT_LAST);

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt + CW'(1);
        w_shift_n   = r_shift;
        w_parity_n  = r_parity;
        w_edge_n    = r_edge;
        w_clk_oe_n  = r_clk_oe;
        w_data_oe_n = r_data_oe;
        w_done_n    = 1'b0;
        w_error_n   = 1'b0;
        w_nack_n    = r_nack;
        w_abort     = 1'b0;

        if (r_state != IDLE && r_state != INHIBIT && w_fall) begin
            w_cnt_n = '0;
        end

        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (tx_valid) begin
                    w_shift_n   = tx_data;
                    w_parity_n  = odd_parity(tx_data);
                    w_nack_n    = 1'b0;
                    w_clk_oe_n  = 1'b1;
                    w_data_oe_n = (INHIBIT_CYCLES == 1);
                    w_state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Data goes low one cycle before the clock is released (request-to-send).
                if (r_cnt == INH_LAST) begin
                    w_clk_oe_n  = 1'b0;
                    w_data_oe_n = 1'b1;
                    w_cnt_n     = '0;
                    w_edge_n    = '0;
                    w_state_n   = REQ;
                end else if (INHIBIT_CYCLES >= 2 && r_cnt == INH_PRE) begin
                    w_data_oe_n = 1'b1;
                end
            end
            REQ: begin
                if (w_fall) begin
                    w_data_oe_n = ~r_shift[0];
                    w_shift_n   = {1'b0, r_shift[7:1]};
                    w_edge_n    = 4'd1;
                    w_state_n   = DATA;
                end else if (w_tout) begin
                    w_abort = 1'b1;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_data_oe_n = ~r_shift[0];
                    w_shift_n   = {1'b0, r_shift[7:1]};
                    w_edge_n    = r_edge + 4'd1;
                    if (r_edge == 4'(DATA_BITS - 1)) begin
                        w_state_n = PARITY;
                    end
                end else if (w_tout) begin
                    w_abort = 1'b1;
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_data_oe_n = ~r_parity;
                    w_edge_n    = 4'(PARITY_EDGE);
                    w_state_n   = STOP;
                end else if (w_tout) begin
                    w_abort = 1'b1;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_data_oe_n = 1'b0;
                    w_edge_n    = 4'(STOP_EDGE);
                    w_state_n   = ACK;
                end else if (w_tout) begin
                    w_abort = 1'b1;
                end
            end
            ACK: begin
                if (w_fall) begin
                    w_edge_n = 4'(ACK_EDGE);
                    if (!ps2_data) begin
                        w_state_n = RELEASE;
                    end else begin
                        w_error_n = 1'b1;
                        w_nack_n  = 1'b1;
                        w_state_n = IDLE;
                    end
                end else if (w_tout) begin
                    w_abort = 1'b1;
                end
            end
            RELEASE: begin
                if (ps2_clk && ps2_data) begin
                    w_done_n  = 1'b1;
                    w_state_n = IDLE;
                end else if (w_tout) begin
                    w_abort = 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_abort) begin
            w_clk_oe_n  = 1'b0;
            w_data_oe_n = 1'b0;
            w_error_n   = 1'b1;
            w_nack_n    = 1'b1;
            w_state_n   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_edge    <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_shift   <= w_shift_n;
            r_parity  <= w_parity_n;
            r_edge    <= w_edge_n;
            r_clk_oe  <= w_clk_oe_n;
            r_data_oe <= w_data_oe_n;
            r_done    <= w_done_n;
            r_error   <= w_error_n;
            r_nack    <= w_nack_n;
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign tx_nack     = r_nack;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

    localparam int INH  = 1000;
    localparam int TOUT = 3000;
    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_error, tx_nack;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .tx_nack     (tx_nack)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] exp_frame_q[$];
    logic [10:0] obs_frame_q[$];
    int          exp_out_q[$];

    int dev_mode  = M_NORMAL;
    int dev_half  = 20;
    int dev_falls = 0;
    bit dev_abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bits in the order the device sees them: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Device model: clocks the frame, samples on rising edges, optionally ACKs.
    initial begin
        int          mode, half;
        bit          aborted;
        logic [10:0] frame;
        forever begin
            @(negedge clk);
            if (!reset && ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) begin
                mode      = dev_mode;
                half      = dev_half;
                frame     = '0;
                aborted   = 1'b0;
                dev_falls = 0;
                if (mode == M_SILENT) begin
                    while (ps2_data_oe) @(negedge clk);
                end else begin
                    repeat (half) @(negedge clk);
                    frame[0] = ps2_data;
                    for (int k = 1; k <= 11; k++) begin
                        if (k == 11 && mode == M_NORMAL) begin
                            dev_data_low = 1'b1;
                            repeat (4) @(negedge clk);
                        end
                        dev_clk_low = 1'b1;
                        dev_falls   = k;
                        repeat (half) @(negedge clk);
                        dev_clk_low = 1'b0;
                        if (k <= 10) frame[k] = ps2_data;
                        repeat (half) @(negedge clk);
                        if (dev_abort) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    dev_data_low = 1'b0;
                    dev_clk_low  = 1'b0;
                    if (aborted) begin
                        while (dev_abort) @(negedge clk);
                    end else begin
                        obs_frame_q.push_back(frame);
                    end
                end
            end
        end
    end

    // Monitor: inhibit timing, completion pulses and device-observed frames.
    initial begin
        int          inh_run = 0;
        int          inh_dat = 0;
        int          since_req = 0;
        logic        prev_clk_oe = 1'b0;
        bit          pend_pulse = 1'b0;
        int          k;
        logic [10:0] o, e;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                inh_run++;
                if (ps2_data_oe) inh_dat++;
            end else if (prev_clk_oe) begin
                chk("inhibit_len", 32'(inh_run), 32'(INH));
                chk("data_low_last_inhibit_cycle", 32'(inh_dat), 32'd1);
                inh_run = 0;
                inh_dat = 0;
            end
            if (prev_clk_oe && !ps2_clk_oe) since_req = 0;
            else since_req++;
            prev_clk_oe = ps2_clk_oe;

            if (pend_pulse) begin
                chk("pulse_one_cycle", 32'(tx_done | tx_error), 32'd0);
                pend_pulse = 1'b0;
            end
            if (tx_done || tx_error) begin
                if (exp_out_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    k = exp_out_q.pop_front();
                    chk("outcome_is_error", 32'(tx_error), 32'(k != M_NORMAL));
                    chk("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
                    chk("nack_flag", 32'(tx_nack), 32'(k != M_NORMAL));
                    chk("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                    chk("ready_at_end", 32'(tx_ready), 32'd1);
                    if (k == M_SILENT) chk("timeout_latency", 32'(since_req), 32'(TOUT));
                end
                pend_pulse = 1'b1;
            end

            if (obs_frame_q.size() > 0) begin
                o = obs_frame_q.pop_front();
                if (exp_frame_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = exp_frame_q.pop_front();
                    chk("frame_bits", 32'(o), 32'(e));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int mode, input bit push);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", 32'(tx_ready), 32'd1);
        dev_mode = mode;
        tx_data  = b;
        tx_valid = 1'b1;
        if (push) begin
            if (mode != M_SILENT) exp_frame_q.push_back(ref_frame(b));
            exp_out_q.push_back(mode);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy || exp_out_q.size() != 0 || exp_frame_q.size() != 0) && n < 3 * TOUT + 5000) begin
            @(negedge clk);
            n++;
        end
        chk("transfer_finished", 32'(busy || exp_out_q.size() != 0 || exp_frame_q.size() != 0), 32'd0);
        exp_out_q.delete();
        exp_frame_q.delete();
        repeat (100) @(negedge clk);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_error", 32'(tx_error), 32'd0);
        chk("rst_nack", 32'(tx_nack), 32'd0);
        reset = 1'b0;

        dev_half = 20;
        send(8'hED, M_NORMAL, 1'b1);
        wait_idle();
        chk("nack_after_ed", 32'(tx_nack), 32'd0);

        send(8'h3C, M_NOACK, 1'b1);
        wait_idle();
        chk("nack_sticky", 32'(tx_nack), 32'd1);
        chk("idle_after_nack", 32'({ps2_clk_oe, ps2_data_oe, tx_ready}), 32'd1);

        send(8'h07, M_NORMAL, 1'b1);
        wait_idle();
        chk("nack_cleared_on_accept", 32'(tx_nack), 32'd0);
        send(8'h00, M_NORMAL, 1'b1);
        wait_idle();

        send(8'hA5, M_SILENT, 1'b1);
        wait_idle();

        // Reset in the middle of the data bits.
        dev_falls = 0;
        send(8'h5A, M_NORMAL, 1'b0);
        n = 0;
        while (dev_falls < 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_data_bit4", 32'(dev_falls >= 5), 32'd1);
        dev_abort = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        chk("midreset_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("midreset_idle", 32'({busy, tx_ready}), 32'd1);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        dev_abort = 1'b0;
        send(8'hFF, M_NORMAL, 1'b1);
        wait_idle();

        // tx_valid held while busy: only the first byte goes, the second waits for IDLE.
        @(negedge clk);
        dev_mode = M_NORMAL;
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        exp_frame_q.push_back(ref_frame(8'hF4));
        exp_out_q.push_back(M_NORMAL);
        exp_frame_q.push_back(ref_frame(8'hAA));
        exp_out_q.push_back(M_NORMAL);
        @(posedge clk);
        #1 tx_data = 8'hAA;
        n = 0;
        @(negedge clk);
        while (!tx_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("f4_done_seen", 32'(tx_done), 32'd1);
        chk("ready_on_done_cycle", 32'(tx_ready), 32'd1);
        @(negedge clk);
        chk("aa_accepted_after_idle", 32'({busy, ps2_clk_oe}), 32'd3);
        tx_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            dev_half = int'($urandom_range(12, 30));
            send(8'($urandom), (($urandom % 4) == 0) ? M_NOACK : M_NORMAL, 1'b1);
            wait_idle();
        end

        chk("scoreboard_drained", 32'(obs_frame_q.size() + exp_frame_q.size() + exp_out_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
